// File: rtl/deck_dealer.sv
// -----------------------------------------------------------------------------
// deck_dealer
//   Card source for the hand controller. A shuffle request rebuilds a 52-card
//   deck and shuffles it in place with Fisher-Yates, drawing swap indices from
//   a 16-bit Galois LFSR. Once shuffled, each deal request returns one card on
//   the following cycle.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset, clears all state
//   shuffle_req  in   pulse: rebuild and shuffle (highest priority)
//   seed[15:0]   in   LFSR seed, sampled with shuffle_req (0 -> SEED_DEFAULT)
//   busy         out  high while the deck is being rebuilt/shuffled
//   ready        out  deck shuffled and at least one card left
//   deal_req     in   request one card
//   burn_req     in   (DECK_DEALER_BURN_EN only) discard the top card
//   deal_valid   out  pulse, deal_card is valid
//   deal_card    out  {suit[1:0], rank[3:0]}, rank 2..14
//   cards_left   out  undealt cards, 0..52
//   deal_err     out  pulse, illegal deal/burn request
//
// Configuration
//   DECK_DEALER_BURN_EN : adds the burn_req input.
// -----------------------------------------------------------------------------
module deck_dealer #(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        shuffle_req,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        ready,
    input  logic        deal_req,
`ifdef DECK_DEALER_BURN_EN
    input  logic        burn_req,
`endif
    output logic        deal_valid,
    output logic [5:0]  deal_card,
    output logic [5:0]  cards_left,
    output logic        deal_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHUF  = 2'd2,
        ST_READY = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [5:0]  deck_r [0:51];
    logic [15:0] lfsr_r;
    logic [5:0]  i_r;
    logic [5:0]  ptr_r;
    logic [5:0]  cards_left_r;
    logic        busy_r;
    logic        ready_r;
    logic        deal_valid_r;
    logic [5:0]  deal_card_r;
    logic        deal_err_r;

    logic        burn_s;
    logic [5:0]  j_s;
    logic        accept_s;
    logic        take_deal_s;
    logic        take_burn_s;
    logic        err_s;
    logic [5:0]  consume_s;
    logic [5:0]  deal_idx_s;

    // One Galois step: shift right, fold taps in when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Card index 0..51 -> {suit, rank}; suit = k/13, rank = k%13 + 2.
    function automatic logic [5:0] card_of(input logic [5:0] k);
        logic [1:0] suit;
        logic [5:0] off;
        if (k < 6'd13) begin
            suit = 2'd0;
            off  = k;
        end else if (k < 6'd26) begin
            suit = 2'd1;
            off  = k - 6'd13;
        end else if (k < 6'd39) begin
            suit = 2'd2;
            off  = k - 6'd26;
        end else begin
            suit = 2'd3;
            off  = k - 6'd39;
        end
        card_of = {suit, off[3:0] + 4'd2};
    endfunction

`ifdef DECK_DEALER_BURN_EN
    assign burn_s = burn_req;
`else
    assign burn_s = 1'b0;
`endif

    assign j_s        = lfsr_r[5:0];
    assign accept_s   = (j_s <= i_r);
    assign consume_s  = {5'd0, take_deal_s} + {5'd0, take_burn_s};
    // A burn in the same cycle pushes the dealt card one slot further down.
    assign deal_idx_s = ptr_r + {5'd0, take_burn_s};

    assign busy       = busy_r;
    assign ready      = ready_r;
    assign deal_valid = deal_valid_r;
    assign deal_card  = deal_card_r;
    assign cards_left = cards_left_r;
    assign deal_err   = deal_err_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and request classification; shuffle_req silently wins over deals.
    always_comb begin
        state_nxt_s = state_r;
        take_deal_s = 1'b0;
        take_burn_s = 1'b0;
        err_s       = 1'b0;
        if (shuffle_req) begin
            state_nxt_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    err_s = deal_req | burn_s;
                end
                ST_LOAD: begin
                    state_nxt_s = ST_SHUF;
                    err_s       = deal_req | burn_s;
                end
                ST_SHUF: begin
                    err_s = deal_req | burn_s;
                    if (accept_s && (i_r == 6'd1)) begin
                        state_nxt_s = ST_READY;
                    end else begin
                        state_nxt_s = ST_SHUF;
                    end
                end
                ST_READY: begin
                    if (cards_left_r == 6'd0) begin
                        err_s = deal_req | burn_s;
                    end else if (burn_s) begin
                        take_burn_s = 1'b1;
                        if (deal_req && (cards_left_r == 6'd1)) begin
                            err_s = 1'b1;
                        end else begin
                            take_deal_s = deal_req;
                        end
                    end else begin
                        take_deal_s = deal_req;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Deck storage: parallel rebuild in LOAD, one swap per accepted SHUF step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 52; k++) begin
                deck_r[k] <= 6'd0;
            end
        end else if (!shuffle_req) begin
            if (state_r == ST_LOAD) begin
                for (int k = 0; k < 52; k++) begin
                    deck_r[k] <= 6'(k);
                end
            end else if ((state_r == ST_SHUF) && accept_s) begin
                deck_r[i_r] <= deck_r[j_s];
                deck_r[j_s] <= deck_r[i_r];
            end
        end
    end

    // Shuffle control, deal pointer, card counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r       <= 16'd0;
            i_r          <= 6'd0;
            ptr_r        <= 6'd0;
            cards_left_r <= 6'd0;
            busy_r       <= 1'b0;
            ready_r      <= 1'b0;
            deal_valid_r <= 1'b0;
            deal_card_r  <= 6'd0;
            deal_err_r   <= 1'b0;
        end else begin
            deal_valid_r <= take_deal_s;
            deal_err_r   <= err_s;
            if (take_deal_s) begin
                deal_card_r <= card_of(deck_r[deal_idx_s]);
            end
            if (shuffle_req) begin
                // Seed is latched here so LOAD only has to rebuild the deck.
                lfsr_r       <= (seed == 16'd0) ? SEED_DEFAULT : seed;
                busy_r       <= 1'b1;
                ready_r      <= 1'b0;
                cards_left_r <= 6'd0;
                ptr_r        <= 6'd0;
            end else begin
                case (state_r)
                    ST_LOAD: begin
                        i_r <= 6'd51;
                    end
                    ST_SHUF: begin
                        lfsr_r <= lfsr_step(lfsr_r);
                        if (accept_s && (i_r == 6'd1)) begin
                            busy_r       <= 1'b0;
                            ready_r      <= 1'b1;
                            cards_left_r <= 6'd52;
                            ptr_r        <= 6'd0;
                        end else if (accept_s) begin
                            i_r <= i_r - 6'd1;
                        end
                    end
                    ST_READY: begin
                        if (consume_s != 6'd0) begin
                            ptr_r        <= ptr_r + consume_s;
                            cards_left_r <= cards_left_r - consume_s;
                            ready_r      <= (cards_left_r != consume_s);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deck_dealer.sv
module tb_deck_dealer;

    logic        clk;
    logic        reset;
    logic        shuffle_req;
    logic [15:0] seed;
    logic        busy;
    logic        ready;
    logic        deal_req;
`ifdef DECK_DEALER_BURN_EN
    logic        burn_req;
`endif
    logic        deal_valid;
    logic [5:0]  deal_card;
    logic [5:0]  cards_left;
    logic        deal_err;

    int checks;
    int passes;
    int exp_order [52];
    int exp_cycles;

    deck_dealer dut (
        .clk         (clk),
        .reset       (reset),
        .shuffle_req (shuffle_req),
        .seed        (seed),
        .busy        (busy),
        .ready       (ready),
        .deal_req    (deal_req),
`ifdef DECK_DEALER_BURN_EN
        .burn_req    (burn_req),
`endif
        .deal_valid  (deal_valid),
        .deal_card   (deal_card),
        .cards_left  (cards_left),
        .deal_err    (deal_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: Fisher-Yates straight from the rules, LFSR via integer arithmetic.
    task automatic model_shuffle(input logic [15:0] sd);
        int d [52];
        int l, i, j, t;
        l = (sd == 16'd0) ? 32'hACE1 : int'(sd);
        for (int k = 0; k < 52; k++) d[k] = k;
        i = 51;
        exp_cycles = 1;
        while (i >= 1 && exp_cycles < 5000) begin
            j = l % 64;
            exp_cycles++;
            if (j <= i) begin
                t = d[i]; d[i] = d[j]; d[j] = t;
                i--;
            end
            l = (l / 2) ^ (((l % 2) == 1) ? 32'hB400 : 32'h0);
        end
        for (int k = 0; k < 52; k++) exp_order[k] = d[k];
    endtask

    function automatic logic [5:0] exp_card(input int k);
        exp_card = 6'(((k / 13) * 16) + (k % 13) + 2);
    endfunction

    task automatic start_shuffle(input logic [15:0] s, input logic with_deal);
        shuffle_req = 1'b1;
        seed        = s;
        deal_req    = with_deal;
        step();
        shuffle_req = 1'b0;
        deal_req    = 1'b0;
    endtask

    task automatic wait_shuffle(input string tag);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt !== exp_cycles) $display("FAIL %s busy_cycles got %0d want %0d", tag, cnt, exp_cycles);
        else passes++;
        checks++;
        if (ready !== 1'b1 || cards_left !== 6'd52)
            $display("FAIL %s ready_after_shuffle got ready=%b left=%0d want ready=1 left=52", tag, ready, cards_left);
        else passes++;
    endtask

    task automatic deal_all(input string tag);
        bit seen [52];
        int dups, idx;
        dups = 0;
        for (int k = 0; k < 52; k++) seen[k] = 1'b0;
        deal_req = 1'b1;
        for (int n = 0; n < 52; n++) begin
            step();
            checks++;
            if (deal_valid !== 1'b1 || deal_card !== exp_card(exp_order[n]) || cards_left !== 6'(51 - n)
                || ready !== (n != 51))
                $display("FAIL %s deal%0d got v=%b card=%h left=%0d rdy=%b want v=1 card=%h left=%0d rdy=%b",
                         tag, n, deal_valid, deal_card, cards_left, ready, exp_card(exp_order[n]), 51 - n, n != 51);
            else passes++;
            idx = int'(deal_card[5:4]) * 13 + int'(deal_card[3:0]) - 2;
            if (idx < 0 || idx > 51 || seen[idx]) dups++;
            else seen[idx] = 1'b1;
        end
        deal_req = 1'b0;
        checks++;
        if (dups !== 0) $display("FAIL %s unique_cards got %0d duplicates want 0", tag, dups);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1; shuffle_req = 1'b0; seed = 16'd0; deal_req = 1'b0;
`ifdef DECK_DEALER_BURN_EN
        burn_req = 1'b0;
`endif
        step(); step();
        checks++;
        if ({busy, ready, deal_valid, deal_card, cards_left, deal_err} !== 15'd0)
            $display("FAIL reset_values got busy=%b rdy=%b v=%b card=%h left=%0d err=%b want all 0",
                     busy, ready, deal_valid, deal_card, cards_left, deal_err);
        else passes++;
        reset = 1'b0;
        step();
        deal_req = 1'b1;
        step();
        deal_req = 1'b0;
        checks++;
        if (deal_err !== 1'b1 || deal_valid !== 1'b0 || cards_left !== 6'd0)
            $display("FAIL idle_deal got err=%b v=%b left=%0d want err=1 v=0 left=0", deal_err, deal_valid, cards_left);
        else passes++;
        step();
        checks++;
        if (deal_err !== 1'b0) $display("FAIL err_pulse got %b want 0", deal_err);
        else passes++;
    endtask

    task automatic test_seed_1234();
        logic [5:0] last;
        model_shuffle(16'h1234);
        start_shuffle(16'h1234, 1'b0);
        wait_shuffle("s1234");
        deal_all("s1234");
        last = exp_card(exp_order[51]);
        deal_req = 1'b1;
        step();
        deal_req = 1'b0;
        checks++;
        if (deal_err !== 1'b1 || deal_valid !== 1'b0 || ready !== 1'b0 || deal_card !== last)
            $display("FAIL deal53 got err=%b v=%b rdy=%b card=%h want err=1 v=0 rdy=0 card=%h",
                     deal_err, deal_valid, ready, deal_card, last);
        else passes++;
    endtask

    task automatic test_seed_zero();
        model_shuffle(16'hACE1);
        start_shuffle(16'h0000, 1'b0);
        wait_shuffle("seed0");
        deal_all("seed0");
    endtask

    task automatic test_restart_mid_shuffle();
        int wait_n;
        wait_n = $urandom_range(3, 40);
        start_shuffle(16'h1234, 1'b0);
        for (int k = 0; k < wait_n; k++) step();
        model_shuffle(16'hBEEF);
        start_shuffle(16'hBEEF, 1'b1);
        checks++;
        if (deal_err !== 1'b0 || deal_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL restart_drop got err=%b v=%b busy=%b want err=0 v=0 busy=1", deal_err, deal_valid, busy);
        else passes++;
        wait_shuffle("beef");
        deal_all("beef");
    endtask

    task automatic test_random_deals();
        logic [15:0] s;
        logic        req;
        int          ptr;
        for (int r = 0; r < 3; r++) begin
            s = 16'($urandom_range(1, 65535));
            model_shuffle(s);
            start_shuffle(s, 1'b0);
            wait_shuffle("rand_shuf");
            ptr = 0;
            for (int c = 0; c < 80; c++) begin
                req = ($urandom_range(0, 9) < 7);
                deal_req = req;
                step();
                checks++;
                if (req && ptr < 52) begin
                    if (deal_valid !== 1'b1 || deal_err !== 1'b0 || deal_card !== exp_card(exp_order[ptr])
                        || cards_left !== 6'(51 - ptr))
                        $display("FAIL rand_deal seed=%h n=%0d got v=%b err=%b card=%h left=%0d want card=%h left=%0d",
                                 s, ptr, deal_valid, deal_err, deal_card, cards_left, exp_card(exp_order[ptr]), 51 - ptr);
                    else passes++;
                    ptr++;
                end else begin
                    if (deal_valid !== 1'b0 || deal_err !== (req && ptr >= 52) || cards_left !== 6'(52 - ptr))
                        $display("FAIL rand_idle seed=%h got v=%b err=%b left=%0d want v=0 err=%b left=%0d",
                                 s, deal_valid, deal_err, cards_left, req && ptr >= 52, 52 - ptr);
                    else passes++;
                end
            end
            deal_req = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        start_shuffle(16'h5A5A, 1'b0);
        step(); step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || cards_left !== 6'd0)
            $display("FAIL async_reset got busy=%b rdy=%b left=%0d want 0 0 0", busy, ready, cards_left);
        else passes++;
        step();
        reset = 1'b0;
        deal_req = 1'b1;
        step();
        deal_req = 1'b0;
        checks++;
        if (deal_err !== 1'b1 || deal_valid !== 1'b0)
            $display("FAIL post_reset_deal got err=%b v=%b want err=1 v=0", deal_err, deal_valid);
        else passes++;
    endtask

`ifdef DECK_DEALER_BURN_EN
    task automatic test_burn();
        logic [15:0] s;
        s = 16'($urandom_range(1, 65535));
        model_shuffle(s);
        start_shuffle(s, 1'b0);
        wait_shuffle("burn_shuf");
        burn_req = 1'b1;
        step();
        burn_req = 1'b0;
        checks++;
        if (deal_valid !== 1'b0 || deal_err !== 1'b0 || cards_left !== 6'd51)
            $display("FAIL burn got v=%b err=%b left=%0d want v=0 err=0 left=51", deal_valid, deal_err, cards_left);
        else passes++;
        deal_req = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            checks++;
            if (deal_valid !== 1'b1 || deal_card !== exp_card(exp_order[n]))
                $display("FAIL burn_deal%0d got v=%b card=%h want v=1 card=%h", n, deal_valid, deal_card,
                         exp_card(exp_order[n]));
            else passes++;
        end
        deal_req = 1'b0;
        checks++;
        if (cards_left !== 6'd48) $display("FAIL burn_left got %0d want 48", cards_left);
        else passes++;
    endtask
`endif

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_seed_1234();
        test_seed_zero();
        test_restart_mid_shuffle();
        test_random_deals();
        test_async_reset();
`ifdef DECK_DEALER_BURN_EN
        test_burn();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/deck_dealer.md
# deck_dealer

Card source for the hand state machine. On request it builds a 52-card deck and shuffles it in place (Fisher-Yates driven by a 16-bit LFSR). It then answers single-card deal requests with one card per request, one cycle later. It is the responder on the controller's dealing and shuffling stages: the controller forwards each dealt card to the player it has enabled and to the board.

## Interface
Parameters:
- SEED_DEFAULT, 16'hACE1: LFSR seed used whenever `seed` is 0 (an all-zero seed would lock the LFSR).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- shuffle_req  in  1  single-cycle pulse that starts a rebuild and shuffle.
- seed  in  16  sampled on the cycle `shuffle_req` is high.
- busy  out  1  high while the deck is being shuffled.
- ready  out  1  high when the deck is shuffled and at least one card remains.
- deal_req  in  1  request one card. Valid only when `ready` is high.
- deal_valid  out  1  single-cycle pulse; `deal_card` is valid.
- deal_card  out  card_t  dealt card, encoded as {suit[5:4], rank[3:0]} per poker_types.svh.
- cards_left  out  6  number of undealt cards, 0..52.
- deal_err  out  1  single-cycle pulse on an illegal `deal_req`.

## Operation
- Storage: `deck[52]` holds 6-bit indices 0..51. Card index k maps to suit = k/13 and rank = (k%13)+2, giving ranks 2..14.
- LFSR: 16-bit Galois. Each step is lfsr ← (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- State IDLE (after reset):
  - Deck is considered empty; `cards_left` = 0.
  - `deal_req` → `deal_err`.
  - `shuffle_req` → LOAD.
- State LOAD (1 cycle):
  - deck[k] ← k for all k, in parallel.
  - lfsr ← seed, or SEED_DEFAULT if seed is 0.
  - i ← 51. Next state is SHUF.
- State SHUF, one LFSR step per cycle, using j = lfsr[5:0] of the current value:
  - If j ≤ i: swap deck[i] and deck[j]. If i = 1, go to READY; otherwise i ← i−1.
  - If j > i: reject, no swap, i unchanged.
- State READY, on entry: ptr ← 0, `cards_left` ← 52.
- READY with `deal_req` and `cards_left` > 0:
  - Next cycle: `deal_card` = card of deck[ptr], `deal_valid` = 1.
  - ptr ← ptr+1; `cards_left` ← `cards_left` − 1.
  - When `cards_left` reaches 0, the block stays in READY with `ready` = 0.
- READY with `deal_req` and `cards_left` = 0: `deal_err` pulse, no `deal_valid`.
- Priority: `shuffle_req` from any state (including mid-SHUF and READY) → LOAD. A `deal_req` in the same cycle is dropped silently, with no error.
- `deal_req` during LOAD or SHUF → `deal_err`, no `deal_valid`.

## Timing
- Reset values: `busy` 0, `ready` 0, `deal_valid` 0, `deal_card` 0, `cards_left` 0, `deal_err` 0. State is IDLE.
- Reset mid-shuffle or mid-deal aborts immediately. Outputs return to reset values asynchronously.
- `busy` is high from the cycle after `shuffle_req` through the last SHUF cycle.
- Shuffle latency is 1 + 51 + (number of rejections) cycles. It is deterministic for a given seed.
- Deal latency: `deal_req` at cycle n gives `deal_valid` at n+1. Back-to-back requests are accepted every cycle.
- `cards_left` updates in the same cycle as `deal_valid`.
- `ready` falls in the cycle `cards_left` becomes 0.
- `deal_err` is registered: request at n gives the pulse at n+1.

## Configuration
- DECK_DEALER_BURN_EN
  - Defined: adds input `burn_req` (1 bit).
    - In READY with cards left, it consumes deck[ptr] with no `deal_valid` and decrements `cards_left`.
    - It has the same error rules as `deal_req`.
    - If `burn_req` and `deal_req` arrive together: burn first, then deal the following card, with `cards_left` − 2. A single remaining card is burned and the deal errors.
  - Undefined: port absent; only `deal_req` consumes cards.

## Test plan
- Reset → deal: assert reset, then `deal_req` → `deal_err` = 1 at the next cycle, `deal_valid` = 0, `cards_left` = 0.
- Seed 16'h1234 shuffle → `busy` for exactly the model-predicted count. Then 52 back-to-back deals: each card matches the reference model, all 52 indices are unique, and `cards_left` steps 52→0.
- 53rd `deal_req` after the deck is exhausted → `deal_err` pulse, `ready` = 0, `deal_card` unchanged.
- Seed 0 → deal order is identical to a shuffle with seed 16'hACE1.
- `shuffle_req` mid-SHUF with new seed 16'hBEEF, plus a simultaneous `deal_req` → `deal_req` is dropped with no error. The restarted shuffle with seed 16'hBEEF produces that seed's model order.
- (DECK_DEALER_BURN_EN) Burn one card, then deal three → the model's cards 1, 2, 3 are output, card 0 is skipped, and `cards_left` = 48.
